// File: rtl/line_burst_adapter.sv
// line_burst_adapter: turns one 256-bit line read/write into a 4-beat 64-bit memory burst
// and returns a single-cycle line response.
module line_burst_adapter (
    input  logic         clk,
    input  logic         rst,
    input  logic         line_read,
    input  logic         line_write,
    input  logic [31:0]  line_address,
    input  logic [255:0] line_wdata,
    output logic         line_resp,
    output logic [255:0] line_rdata,
    output logic         burst_read,
    output logic         burst_write,
    output logic [31:0]  burst_address,
    output logic [63:0]  burst_wdata,
    input  logic [63:0]  burst_rdata,
    input  logic         burst_resp
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
    state_t       state;
    logic [1:0]   beat;
    logic [255:0] write_buf;
    logic [255:0] read_buf;
    assign line_rdata  = read_buf;
    assign burst_wdata = write_buf[{beat, 6'd0} +: 64];
    always_ff @(posedge clk)
        if (!rst) begin
            state         <= IDLE;
            beat          <= '0;
            write_buf     <= '0;
            read_buf      <= '0;
            burst_address <= '0;
            burst_read    <= 1'b0;
            burst_write   <= 1'b0;
            line_resp     <= 1'b0;
        end else
            case (state)
                IDLE:
                    if (line_write || line_read) begin
                        burst_address <= {line_address[31:5], 5'b0};
                        beat          <= '0;
                        state         <= line_write ? WRITE : READ;
                        burst_write   <= line_write;
                        burst_read    <= !line_write;
                        if (line_write) write_buf <= line_wdata;
                    end
                READ, WRITE:
                    if (burst_resp) begin
                        if (state == READ) read_buf[{beat, 6'd0} +: 64] <= burst_rdata;
                        beat <= beat + 2'd1;
                        if (beat == 2'd3) begin
                            state       <= DONE;
                            burst_read  <= 1'b0;
                            burst_write <= 1'b0;
                            line_resp   <= 1'b1;
                        end
                    end
                default: begin
                    line_resp <= 1'b0;
                    state     <= IDLE;
                end
            endcase
endmodule
